// File: rtl/gb_apu_pkg.sv
// Shared APU constants: length-field widths used when instantiating
// gb_apu_function_length in each sound channel.
package gb_apu_pkg;

  // Square and noise channels have a 6-bit length field, wave has 8 bits.
  localparam int LENGTH_WIDTH_PULSE = 6;
  localparam int LENGTH_WIDTH_NOISE = 6;
  localparam int LENGTH_WIDTH_WAVE  = 8;

endpackage

// File: rtl/gb_apu_up_counter_ovf.sv
// WIDTH-bit loadable up-counter with an overflow pulse.
// load has priority over inc. ovf is high in the cycle where an accepted
// increment carries out of the top bit, which is when the count wraps to 0.
module gb_apu_up_counter_ovf
  import gb_apu_pkg::*;
#(
  parameter int WIDTH = LENGTH_WIDTH_PULSE
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             inc,
  output logic [WIDTH-1:0] count,
  output logic             ovf
);

  logic [WIDTH-1:0] count_reg;
  logic [WIDTH-1:0] count_next;
  logic [WIDTH-1:0] sum;
  logic [WIDTH:0]   carry;

  // Increment-by-one as an explicit ripple chain so the carry out is a
  // named signal that directly flags the wrap.
  assign carry[0] = 1'b1;
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_inc
      assign sum[gi]      = count_reg[gi] ^ carry[gi];
      assign carry[gi+1]  = count_reg[gi] & carry[gi];
    end
  endgenerate

  // Next-count selection: load wins, otherwise increment when asked.
  always_comb begin
    count_next = count_reg;
    if (load) begin
      count_next = load_value;
    end else if (inc) begin
      count_next = sum;
    end
  end

  // Counter register with asynchronous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

  assign count = count_reg;
  assign ovf   = inc & ~load & carry[WIDTH];

endmodule

// File: rtl/gb_apu_function_length.sv
// Length timer for one APU sound channel.
// A trigger loads the initial length and enables the channel; while
// length-enable mode is set, each frame-sequencer tick advances the counter
// and the tick that wraps it past all-ones silences the channel.
// Optional: define GB_APU_LENGTH_ASSERT_EN to compile behavioural assertions.
module gb_apu_function_length
  import gb_apu_pkg::*;
#(
  parameter int WIDTH = LENGTH_WIDTH_PULSE
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clk_length_ctr,
  input  logic             start,
  input  logic             single,
  input  logic [WIDTH-1:0] length,
  output logic             enable
);

  logic             enable_reg;
  logic             enable_next;
  logic             tick_accept;
  logic [WIDTH-1:0] count;
  logic             ovf;

  // A tick only counts when not overridden by a trigger, in length-enable
  // mode, and while the channel is still running. An expired channel
  // therefore ignores ticks and the counter rests at 0 until retriggered.
  assign tick_accept = clk_length_ctr & ~start & single & enable_reg;

  gb_apu_up_counter_ovf #(
    .WIDTH (WIDTH)
  ) u_counter (
    .clk        (clk),
    .reset      (reset),
    .load       (start),
    .load_value (length),
    .inc        (tick_accept),
    .count      (count),
    .ovf        (ovf)
  );

  // Enable flag: set by trigger, cleared by the wrapping tick.
  always_comb begin
    enable_next = enable_reg;
    if (start) begin
      enable_next = 1'b1;
    end else if (ovf) begin
      enable_next = 1'b0;
    end
  end

  // Registered channel enable with asynchronous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      enable_reg <= 1'b0;
    end else begin
      enable_reg <= enable_next;
    end
  end

  assign enable = enable_reg;

`ifdef GB_APU_LENGTH_ASSERT_EN
  // The channel can only become audible as the result of a trigger.
  a_rise_after_start : assert property (
    @(posedge clk) disable iff (reset)
      $rose(enable_reg) |-> $past(start)
  );

  // With length-enable mode off and no trigger, the counter is frozen.
  a_hold_when_not_single : assert property (
    @(posedge clk) disable iff (reset)
      (!single && !start) |=> $stable(count)
  );

  // The channel only goes silent on a tick taken from the all-ones count.
  a_fall_on_expiry : assert property (
    @(posedge clk) disable iff (reset)
      $fell(enable_reg) |-> $past(clk_length_ctr && !start && (count == '1))
  );
`endif

endmodule

// File: tb/tb_gb_apu_function_length.sv
// Bench for gb_apu_function_length: a 6-bit and an 8-bit instance share
// clock, reset, trigger, tick and mode inputs. A behavioural remaining-ticks
// model pushes the expected enables into a queue as each cycle is driven;
// the entry is popped and compared after the clock edge.
module tb_gb_apu_function_length;
  import gb_apu_pkg::*;

  localparam int W6 = LENGTH_WIDTH_PULSE;
  localparam int W8 = LENGTH_WIDTH_WAVE;

  logic          clk;
  logic          reset;
  logic          clk_length_ctr;
  logic          start;
  logic          single;
  logic [W6-1:0] length6;
  logic [W8-1:0] length8;
  logic          enable6;
  logic          enable8;

  gb_apu_function_length #(.WIDTH(W6)) dut6 (
    .clk            (clk),
    .reset          (reset),
    .clk_length_ctr (clk_length_ctr),
    .start          (start),
    .single         (single),
    .length         (length6),
    .enable         (enable6)
  );

  gb_apu_function_length #(.WIDTH(W8)) dut8 (
    .clk            (clk),
    .reset          (reset),
    .clk_length_ctr (clk_length_ctr),
    .start          (start),
    .single         (single),
    .length         (length8),
    .enable         (enable8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic e6;
    logic e8;
  } exp_t;

  exp_t sb_q[$];

  int checks;
  int errors;

  // Model state: ticks remaining until expiry and expected enable.
  int rem6, rem8;
  bit en6, en8;

  // Tick bookkeeping for drop-position checks.
  int tick_n, drop6, drop8;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic begin_watch();
    tick_n = 0;
    drop6  = -1;
    drop8  = -1;
  endtask

  task automatic model_step(input logic s, input logic t);
    if (s) begin
      rem6 = (1 << W6) - int'(length6);
      rem8 = (1 << W8) - int'(length8);
      en6  = 1'b1;
      en8  = 1'b1;
    end else if (t && single) begin
      if (en6) begin
        rem6--;
        if (rem6 == 0) en6 = 1'b0;
      end
      if (en8) begin
        rem8--;
        if (rem8 == 0) en8 = 1'b0;
      end
    end
  endtask

  // One clock cycle: drive at the falling edge, check one step after rising.
  task automatic cycle(input string tag, input logic s, input logic t);
    exp_t e;
    start          = s;
    clk_length_ctr = t;
    model_step(s, t);
    sb_q.push_back('{e6: en6, e8: en8});
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    check({tag, ".en6"}, int'(enable6), int'(e.e6));
    check({tag, ".en8"}, int'(enable8), int'(e.e8));
    $display("cycle %s start=%0b tick=%0b single=%0b en6=%0b en8=%0b",
             tag, s, t, single, enable6, enable8);
    if (t && !s) tick_n++;
    if (drop6 < 0 && !enable6) drop6 = tick_n;
    if (drop8 < 0 && !enable8) drop8 = tick_n;
    @(negedge clk);
    start          = 1'b0;
    clk_length_ctr = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1;
    start = 1'b0;
    clk_length_ctr = 1'b0;
    single = 1'b1;
    length6 = '0;
    length8 = '0;
    en6 = 1'b0;
    en8 = 1'b0;
    rem6 = 0;
    rem8 = 0;
    begin_watch();

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("reset.en6", int'(enable6), 0);
    check("reset.en8", int'(enable8), 0);
    @(negedge clk);
    reset = 1'b0;

    // Ticks before any trigger do nothing.
    for (int i = 0; i < 3; i++) cycle("pretrig", 1'b0, 1'b1);

    // Test 1: length 60, start held two cycles, drop on the 4th tick.
    single  = 1'b1;
    length6 = 6'd60;
    length8 = 8'd252;
    cycle("t1.start", 1'b1, 1'b0);
    cycle("t1.start", 1'b1, 1'b0);
    begin_watch();
    for (int i = 0; i < 10; i++) cycle("t1.tick", 1'b0, 1'b1);
    check("t1.drop6", drop6, 4);
    check("t1.drop8", drop8, 4);

    // Test 2: continuous mode freezes the counter, then length mode resumes.
    single = 1'b0;
    cycle("t2.start", 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) cycle("t2.cont", 1'b0, 1'b1);
    check("t2.still_on6", int'(enable6), 1);
    single = 1'b1;
    length6 = 6'd5;   // changing length mid-play must not matter
    length8 = 8'd7;
    begin_watch();
    for (int i = 0; i < 4; i++) cycle("t2.tick", 1'b0, 1'b1);
    check("t2.drop6", drop6, 4);
    check("t2.drop8", drop8, 4);

    // Test 3: length 0 gives the full range of ticks.
    length6 = '0;
    length8 = '0;
    cycle("t3.start", 1'b1, 1'b0);
    begin_watch();
    for (int i = 0; i < 260; i++) cycle("t3.tick", 1'b0, 1'b1);
    check("t3.drop6", drop6, 64);
    check("t3.drop8", drop8, 256);

    // Test 4: trigger coincident with a tick discards the tick.
    length6 = 6'd62;
    length8 = 8'd254;
    cycle("t4.start_tick", 1'b1, 1'b1);
    begin_watch();
    for (int i = 0; i < 4; i++) cycle("t4.tick", 1'b0, 1'b1);
    check("t4.drop6", drop6, 2);
    check("t4.drop8", drop8, 2);

    // Test 5: expired channel ignores ticks; retrigger with max length.
    for (int i = 0; i < 5; i++) cycle("t5.dead", 1'b0, 1'b1);
    check("t5.dead6", int'(enable6), 0);
    length6 = 6'd63;
    length8 = 8'd255;
    cycle("t5.start", 1'b1, 1'b0);
    check("t5.on6", int'(enable6), 1);
    begin_watch();
    for (int i = 0; i < 3; i++) cycle("t5.tick", 1'b0, 1'b1);
    check("t5.drop6", drop6, 1);
    check("t5.drop8", drop8, 1);

    // Test 6: asynchronous reset mid-count clears at once.
    length6 = 6'd10;
    length8 = 8'd10;
    cycle("t6.start", 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cycle("t6.tick", 1'b0, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    en6 = 1'b0;
    en8 = 1'b0;
    check("t6.async6", int'(enable6), 0);
    check("t6.async8", int'(enable8), 0);
    $display("async reset en6=%0b en8=%0b", enable6, enable8);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) cycle("t6.after", 1'b0, 1'b1);

    check("sb_empty", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
